ysyx_22050710_redirect_ctrl: RTL and testbench

Front-end redirect sequencer between the ID-stage branch unit, the trap/CSR logic and the IF stage. It captures a taken branch (including ecall/mret targets already merged by the branch unit) or a later-stage trap redirect, and holds it until IF can start a new fetch. It flushes the IF/ID register for the whole wrong-path window. It then kills every stale fetch response still in flight from the old PC stream.

---
 rtl/ysyx_22050710_redirect_ctrl_pkg.sv | 14 +
 rtl/ysyx_22050710_redirect_ctrl_if.sv | 33 +++
 rtl/ysyx_22050710_drop_cnt.sv | 30 +++
 rtl/ysyx_22050710_redirect_ctrl.sv | 100 ++++++++++
 tb/tb_ysyx_22050710_redirect_ctrl.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/ysyx_22050710_redirect_ctrl_pkg.sv
// Shared types and defaults for the front-end redirect sequencer.
package ysyx_22050710_redirect_ctrl_pkg;

  localparam int unsigned DefPcWd     = 32;
  localparam int unsigned DefMaxOutst = 2;

  // Redirect sequencer states.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StHold  = 2'd1,
    StDrain = 2'd2
  } redirect_state_e;

endpackage

// File: rtl/ysyx_22050710_redirect_ctrl_if.sv
// Signal bundle between ID/trap/IF and the redirect sequencer.
// slave = the sequencer, master = the surrounding pipeline.
interface ysyx_22050710_redirect_ctrl_if #(
  parameter int unsigned PC_WD     = 32,
  parameter int unsigned MAX_OUTST = 2
);
  localparam int unsigned OW = $clog2(MAX_OUTST + 1);

  logic             i_id_valid;
  logic             i_br_taken;
  logic [PC_WD-1:0] i_br_target;
  logic             i_trap_valid;
  logic [PC_WD-1:0] i_trap_target;
  logic             i_redirect_ready;
  logic [OW-1:0]    i_if_outst;
  logic             i_if_resp_fire;
  logic             o_redirect_valid;
  logic [PC_WD-1:0] o_redirect_pc;
  logic             o_flush;
  logic             o_resp_kill;

  modport slave (
    input  i_id_valid, i_br_taken, i_br_target, i_trap_valid, i_trap_target,
    input  i_redirect_ready, i_if_outst, i_if_resp_fire,
    output o_redirect_valid, o_redirect_pc, o_flush, o_resp_kill
  );

  modport master (
    output i_id_valid, i_br_taken, i_br_target, i_trap_valid, i_trap_target,
    output i_redirect_ready, i_if_outst, i_if_resp_fire,
    input  o_redirect_valid, o_redirect_pc, o_flush, o_resp_kill
  );
endinterface

// File: rtl/ysyx_22050710_drop_cnt.sv
// Loadable down-counter tracking stale fetch responses still to be dropped.
module ysyx_22050710_drop_cnt #(
  parameter int unsigned OW = 2
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_load,
  input  logic [OW-1:0] i_load_val,
  input  logic          i_dec,
  output logic [OW-1:0] o_cnt,
  output logic          o_zero
);

  logic [OW-1:0] cnt_q;

  // Load wins over decrement; saturate at zero so a stray dec cannot wrap.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else if (i_load) begin
      cnt_q <= i_load_val;
    end else if (i_dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - OW'(1);
    end
  end

  assign o_cnt  = cnt_q;
  assign o_zero = (cnt_q == '0);

endmodule

// File: rtl/ysyx_22050710_redirect_ctrl.sv
// Front-end redirect sequencer: captures branch/trap redirects, holds them
// until IF accepts, flushes IF/ID meanwhile and kills stale fetch responses.
module ysyx_22050710_redirect_ctrl
  import ysyx_22050710_redirect_ctrl_pkg::*;
#(
  parameter int unsigned PC_WD     = DefPcWd,
  parameter int unsigned MAX_OUTST = DefMaxOutst
) (
  input logic i_clk,
  input logic i_rst,
  ysyx_22050710_redirect_ctrl_if.slave bus
);

  localparam int unsigned OW = $clog2(MAX_OUTST + 1);

  redirect_state_e  state_q, state_d;
  logic [PC_WD-1:0] target_q, target_d;

  logic          cap_br;
  logic          cap_trap;
  logic          accept;
  logic          cnt_load;
  logic          cnt_dec;
  logic [OW-1:0] cnt_load_val;
  logic [OW-1:0] drop_cnt;
  logic          drop_zero;

  assign cap_trap     = bus.i_trap_valid;
  assign cap_br       = (state_q == StIdle) && bus.i_id_valid && bus.i_br_taken && !cap_trap;
  assign accept       = (state_q == StHold) && bus.i_redirect_ready;
  // A response landing in the accept cycle answers one of the outstanding requests.
  assign cnt_load_val = bus.i_if_outst - OW'(bus.i_if_resp_fire);

  ysyx_22050710_drop_cnt #(
    .OW (OW)
  ) u_drop_cnt (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (cnt_load),
    .i_load_val (cnt_load_val),
    .i_dec      (cnt_dec),
    .o_cnt      (drop_cnt),
    .o_zero     (drop_zero)
  );

  // State and latched redirect target.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= StIdle;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
    end
  end

  // Next-state: branch capture in IDLE, accept/drain progression, trap overrides all.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cap_br) begin
          state_d  = StHold;
          target_d = bus.i_br_target;
        end
      end
      StHold: begin
        if (accept) begin
          cnt_load = 1'b1;
          state_d  = (cnt_load_val != '0) ? StDrain : StIdle;
        end
      end
      StDrain: begin
        cnt_dec = bus.i_if_resp_fire;
        if ((bus.i_if_resp_fire && (drop_cnt == OW'(1))) || drop_zero) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // A trap always re-arms HOLD; the drop count is reloaded at its own accept.
    if (cap_trap) begin
      state_d  = StHold;
      target_d = bus.i_trap_target;
      cnt_load = 1'b0;
    end
  end

  // Combinational outputs towards IF and the IF/ID register.
  always_comb begin
    bus.o_redirect_valid = (state_q == StHold);
    bus.o_redirect_pc    = target_q;
    bus.o_flush          = cap_br || cap_trap || (state_q != StIdle);
    bus.o_resp_kill      = bus.i_if_resp_fire && (state_q != StIdle);
  end

endmodule

// File: tb/tb_ysyx_22050710_redirect_ctrl.sv
// Scoreboard bench: stimulus pushes the expected per-cycle outputs, a monitor
// on the falling edge pops and compares them.
module tb_ysyx_22050710_redirect_ctrl;

  localparam int unsigned PC_WD     = 32;
  localparam int unsigned MAX_OUTST = 2;

  typedef struct {
    logic        chk;
    logic        v;
    logic [31:0] pc;
    logic        cpc;
    logic        fl;
    logic        kl;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t expq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  ysyx_22050710_redirect_ctrl_if #(
    .PC_WD     (PC_WD),
    .MAX_OUTST (MAX_OUTST)
  ) bus ();

  ysyx_22050710_redirect_ctrl #(
    .PC_WD     (PC_WD),
    .MAX_OUTST (MAX_OUTST)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  // Monitor: every cycle the DUT presents outputs; compare against the queue head.
  always @(negedge clk) begin
    if (expq.size() > 0) begin
      exp_t e;
      logic [34:0] act, req;
      e = expq.pop_front();
      if (e.chk) begin
        act = {bus.o_redirect_valid, bus.o_flush, bus.o_resp_kill,
               (e.v || e.cpc) ? bus.o_redirect_pc : 32'h0};
        req = {e.v, e.fl, e.kl, (e.v || e.cpc) ? e.pc : 32'h0};
        n_cmp++;
        if (act !== req) begin
          n_bad++;
          $display("FAIL %s: got v=%b fl=%b kl=%b pc=%h, want v=%b fl=%b kl=%b pc=%h",
                   e.name, act[34], act[33], act[32], act[31:0],
                   req[34], req[33], req[32], req[31:0]);
        end
      end
    end
  end

  // One clock of stimulus plus its expected outputs in that same cycle.
  task automatic step(input string nm, input logic r, input logic idv, input logic brt,
                      input logic [31:0] brtg, input logic trv, input logic [31:0] trtg,
                      input logic rdy, input logic [1:0] ost, input logic rf,
                      input logic chk, input logic ev, input logic [31:0] epc,
                      input logic cpc, input logic efl, input logic ekl);
    exp_t e;
    @(posedge clk);
    #1;
    rst                  = r;
    bus.i_id_valid       = idv;
    bus.i_br_taken       = brt;
    bus.i_br_target      = brtg;
    bus.i_trap_valid     = trv;
    bus.i_trap_target    = trtg;
    bus.i_redirect_ready = rdy;
    bus.i_if_outst       = ost;
    bus.i_if_resp_fire   = rf;
    e.chk = chk; e.v = ev; e.pc = epc; e.cpc = cpc; e.fl = efl; e.kl = ekl; e.name = nm;
    expq.push_back(e);
  endtask

  // Quiet cycle (no requests) with expected outputs.
  task automatic quiet(input string nm, input logic rf, input logic ev, input logic [31:0] epc,
                       input logic efl, input logic ekl);
    step(nm, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 2'd0, rf, 1'b1, ev, epc, 1'b0,
         efl, ekl);
  endtask

  task automatic branch(input string nm, input logic [31:0] tg);
    step(nm, 1'b0, 1'b1, 1'b1, tg, 1'b0, 32'h0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0,
         1'b1, 1'b0);
  endtask

  task automatic accept(input string nm, input logic [1:0] ost, input logic rf,
                        input logic [31:0] epc, input logic ekl);
    step(nm, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, ost, rf, 1'b1, 1'b1, epc, 1'b0,
         1'b1, ekl);
  endtask

  initial begin
    bus.i_id_valid       = 1'b0;
    bus.i_br_taken       = 1'b0;
    bus.i_br_target      = '0;
    bus.i_trap_valid     = 1'b0;
    bus.i_trap_target    = '0;
    bus.i_redirect_ready = 1'b0;
    bus.i_if_outst       = '0;
    bus.i_if_resp_fire   = 1'b0;

    // Reset held two cycles, not checked while asserted.
    step("rst0", 1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 0, 0, 0, 0, 0);
    step("rst1", 1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 0, 0, 0, 0, 0);
    step("reset_state", 1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Branch in IDLE, accepted at T+1 with nothing outstanding.
    branch("br_capture_flush", 32'h8000_0040);
    accept("br_redirect", 2'd0, 1'b0, 32'h8000_0040, 1'b0);
    quiet("br_back_idle", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

    // Trap and branch in the same cycle: trap wins.
    step("trap_vs_br_cap", 1'b0, 1, 1, 32'h100, 1, 32'h8000_0000, 0, 0, 0,
         1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    accept("trap_vs_br_pc", 2'd0, 1'b0, 32'h8000_0000, 1'b0);
    quiet("trap_vs_br_idle", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

    // IF busy 3 cycles; trap overwrites target in 2nd HOLD cycle; branch ignored in HOLD.
    branch("busy_cap", 32'h8000_1000);
    quiet("busy_hold1", 1'b0, 1'b1, 32'h8000_1000, 1'b1, 1'b0);
    step("busy_hold2_trap", 1'b0, 0, 0, 0, 1, 32'h200, 0, 0, 0,
         1'b1, 1'b1, 32'h8000_1000, 1'b0, 1'b1, 1'b0);
    step("busy_hold3_br_ign", 1'b0, 1, 1, 32'hdead_beef, 0, 0, 0, 0, 0,
         1'b1, 1'b1, 32'h200, 1'b0, 1'b1, 1'b0);
    accept("busy_accept", 2'd0, 1'b0, 32'h200, 1'b0);
    quiet("busy_idle", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

    // Drain two stale responses (spaced 1 and 4 cycles); third one passes.
    branch("drain_cap", 32'h3000);
    accept("drain_accept", 2'd2, 1'b0, 32'h3000, 1'b0);
    quiet("drain_kill1", 1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    step("drain_br_ign", 1'b0, 1, 1, 32'h9999, 0, 0, 0, 0, 0,
         1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    quiet("drain_wait2", 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    quiet("drain_wait3", 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    quiet("drain_kill2", 1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    quiet("drain_third_pass", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);

    // Accept with one outstanding answered in the same cycle: straight to IDLE.
    branch("same_cyc_cap", 32'h4000);
    accept("same_cyc_accept_kill", 2'd1, 1'b1, 32'h4000, 1'b1);
    quiet("same_cyc_idle", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);

    // Trap while draining re-enters HOLD, then reloads the count on its accept.
    branch("tdrain_cap", 32'h6000);
    accept("tdrain_accept", 2'd2, 1'b0, 32'h6000, 1'b0);
    step("tdrain_trap", 1'b0, 0, 0, 0, 1, 32'h700, 0, 0, 0,
         1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    accept("tdrain_reaccept", 2'd1, 1'b0, 32'h700, 1'b0);
    quiet("tdrain_kill", 1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    quiet("tdrain_pass", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);

    // Reset in the middle of DRAIN with one response still to drop.
    branch("rdrain_cap", 32'h5000);
    accept("rdrain_accept", 2'd2, 1'b0, 32'h5000, 1'b0);
    quiet("rdrain_kill1", 1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    step("rdrain_rst", 1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    step("rdrain_after_rst", 1'b0, 0, 0, 0, 0, 0, 0, 0, 0,
         1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    quiet("rdrain_no_kill", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    quiet("tail", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

    // Let the monitor drain the scoreboard, bounded.
    for (int i = 0; i < 20 && expq.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (expq.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", expq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, want finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
